// File: rtl/gb_joypad_pkg.sv
// gb_joypad_pkg: button indices, P1 register constants and the P1 nibble matrix helper.
package gb_joypad_pkg;
    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_A      = 4;
    localparam int BTN_B      = 5;
    localparam int BTN_SELECT = 6;
    localparam int BTN_START  = 7;
    localparam logic [15:0] P1_ADDR = 16'hFF00;
    localparam int P14_BIT = 4;
    localparam int P15_BIT = 5;
    localparam logic [7:0] P1_RESET = 8'hFF;
    // Active-low read nibble: a line is pulled low by any pressed key in a selected group.
    function automatic logic [3:0] p1_nibble(input logic [1:0] sel, input logic [7:0] pressed);
        return ~(({4{~sel[0]}} & pressed[BTN_DOWN:BTN_RIGHT]) | ({4{~sel[1]}} & pressed[BTN_START:BTN_A]));
    endfunction
endpackage

// File: rtl/gb_joypad_if.sv
// gb_joypad_if: CPU-side P1 register access and joypad interrupt request.
interface gb_joypad_if;
    logic       p1_sel;
    logic       p1_wr;
    logic [7:0] p1_wdata;
    logic [7:0] p1_rdata;
    logic       irq;
    modport master (output p1_sel, p1_wr, p1_wdata, input p1_rdata, irq);
    modport slave (input p1_sel, p1_wr, p1_wdata, output p1_rdata, irq);
endinterface

// File: rtl/gb_joypad_key_debounce.sv
// key_debounce: 2-flop synchroniser and stable-level debounce for a single button, pressed=1 out.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          w_diff;
    logic          w_flip;

    assign w_diff   = (r_sync[1] ^ RAW_ACTIVE_LOW) != r_stable;
    assign w_flip   = w_diff && (r_cnt == LAST);
    assign o_stable = r_stable;

    // Synchroniser resets to the released level so no phantom press follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= {2{RAW_ACTIVE_LOW}};
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_raw};
            r_cnt    <= (!w_diff || w_flip) ? '0 : r_cnt + 1'b1;
            r_stable <= r_stable ^ w_flip;
        end
    end
endmodule

// File: rtl/gb_joypad.sv
// gb_joypad: P1 (0xFF00) joypad responder with debounce, select matrix and fall-edge irq.
// Optional JOYPAD_TURBO_EN adds a turbo input that pulses A/B at a 2*TURBO_PERIOD rate.
module gb_joypad
    import gb_joypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit RAW_ACTIVE_LOW  = 1'b1
`ifdef JOYPAD_TURBO_EN
    ,
    parameter int TURBO_PERIOD    = 2500000
`endif
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  buttons_raw,
`ifdef JOYPAD_TURBO_EN
    input  logic        turbo,
`endif
    output logic [7:0]  key_state,
    gb_joypad_if.slave  bus
);
    logic [1:0] r_sel;
    logic [7:0] r_rdata;
    logic       r_irq;
    logic [7:0] w_pressed;
    logic [3:0] w_nibble;
    logic       w_unused;

    for (genvar i = 0; i < 8; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
        ) u_db (
            .clk     (CLOCK_50),
            .rst     (reset),
            .i_raw   (buttons_raw[i]),
            .o_stable(key_state[i])
        );
    end

`ifdef JOYPAD_TURBO_EN
    localparam int TW = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TURBO_PERIOD - 1);

    logic [TW-1:0] r_turbo_cnt;
    logic          r_wave;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_turbo_cnt <= '0;
            r_wave      <= 1'b0;
        end else begin
            r_turbo_cnt <= (r_turbo_cnt == TLAST) ? '0 : r_turbo_cnt + 1'b1;
            r_wave      <= r_wave ^ (r_turbo_cnt == TLAST);
        end
    end

    // key_state stays the raw debounced level; only the matrix sees the gated A/B.
    always_comb begin
        w_pressed               = key_state;
        w_pressed[BTN_A]        = key_state[BTN_A] & (~turbo | r_wave);
        w_pressed[BTN_B]        = key_state[BTN_B] & (~turbo | r_wave);
    end
`else
    assign w_pressed = key_state;
`endif

    assign w_nibble     = p1_nibble(r_sel, w_pressed);
    assign w_unused     = &{1'b0, bus.p1_wdata[7:6], bus.p1_wdata[3:0]};
    assign bus.p1_rdata = r_rdata;
    assign bus.irq      = r_irq;

    // irq compares the outgoing registered nibble with the one about to be registered.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sel   <= 2'b11;
            r_rdata <= P1_RESET;
            r_irq   <= 1'b0;
        end else begin
            if (bus.p1_sel && bus.p1_wr)
                r_sel <= bus.p1_wdata[P15_BIT:P14_BIT];
            r_rdata <= {2'b11, r_sel, w_nibble};
            r_irq   <= |(r_rdata[3:0] & ~w_nibble);
        end
    end
endmodule

// File: tb/tb_gb_joypad.sv
// tb_gb_joypad: scoreboard bench; a per-edge reference model queues expectations, a negedge monitor checks.
module tb_gb_joypad;
    localparam int DC = 4;

    typedef struct packed {
        logic [7:0] rdata;
        logic       irq;
        logic [7:0] keys;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] raw = 8'hFF;
    logic [7:0] key_state;
    int         errors = 0;
    int         checks = 0;
    exp_t       q[$];

    logic [1:0] m_sel;
    logic [7:0] m_stable;
    logic [7:0] m_rdata;
    logic [7:0] m_hist[$];

    gb_joypad_if bus();

    gb_joypad #(
        .DEBOUNCE_CYCLES(DC),
        .RAW_ACTIVE_LOW (1'b1)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (rst),
        .buttons_raw(raw),
`ifdef JOYPAD_TURBO_EN
        .turbo      (1'b0),
`endif
        .key_state  (key_state),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_nibble(input logic [1:0] sel, input logic [7:0] p);
        logic [3:0] n;
        for (int b = 0; b < 4; b++) begin
            n[b] = !(((sel[0] == 1'b0) && p[b]) || ((sel[1] == 1'b0) && p[b+4]));
        end
        return n;
    endfunction

    task automatic m_reset();
        m_sel    = 2'b11;
        m_stable = 8'h00;
        m_rdata  = 8'hFF;
        m_hist   = {};
        repeat (DC + 2) m_hist.push_back(8'h00);
    endtask

    // Reference: a key's level is accepted once its synced sample (raw delayed two
    // edges) has disagreed with the accepted level for DC consecutive edges.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reset();
            q.delete();
            q.push_back('{rdata: 8'hFF, irq: 1'b0, keys: 8'h00});
        end else begin
            logic [3:0] nib;
            logic       irq;
            logic       all_diff;
            nib = ref_nibble(m_sel, m_stable);
            irq = |(m_rdata[3:0] & ~nib);
            m_rdata = {2'b11, m_sel, nib};
            if (bus.p1_sel && bus.p1_wr) m_sel = bus.p1_wdata[5:4];
            m_hist.push_front(~raw);
            void'(m_hist.pop_back());
            for (int b = 0; b < 8; b++) begin
                all_diff = 1'b1;
                for (int k = 2; k < DC + 2; k++)
                    if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
                if (all_diff) m_stable[b] = ~m_stable[b];
            end
            q.push_back('{rdata: m_rdata, irq: irq, keys: m_stable});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_queue_empty got=0 entries required>=1 at %0t", $time);
        end else begin
            e = q.pop_front();
            checks += 3;
            if (bus.p1_rdata !== e.rdata) begin
                errors++;
                $display("FAIL sb_rdata got=%h exp=%h at %0t", bus.p1_rdata, e.rdata, $time);
            end
            if (bus.irq !== e.irq) begin
                errors++;
                $display("FAIL sb_irq got=%b exp=%b at %0t", bus.irq, e.irq, $time);
            end
            if (key_state !== e.keys) begin
                errors++;
                $display("FAIL sb_keys got=%h exp=%h at %0t", key_state, e.keys, $time);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.p1_sel   = 1'b1;
        bus.p1_wr    = 1'b1;
        bus.p1_wdata = d;
        tick(1);
        bus.p1_sel   = 1'b0;
        bus.p1_wr    = 1'b0;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        bus.p1_sel   = 1'b0;
        bus.p1_wr    = 1'b0;
        bus.p1_wdata = 8'h00;
        tick(3);
        rst = 1'b0;
        chk("reset_rdata", bus.p1_rdata, 8'hFF);
        chk("reset_irq", {7'd0, bus.irq}, 8'h00);
        chk("reset_keys", key_state, 8'h00);
        // Directions selected, left held: accepted after 2 sync + DC edges.
        wr(8'h20);
        raw[1] = 1'b0;
        tick(6);
        chk("left_keys", key_state, 8'h02);
        chk("left_rdata_pre", bus.p1_rdata, 8'hEF);
        tick(1);
        chk("left_rdata", bus.p1_rdata, 8'hED);
        chk("left_irq", {7'd0, bus.irq}, 8'h01);
        tick(1);
        chk("left_irq_end", {7'd0, bus.irq}, 8'h00);
        raw = 8'hFF;
        tick(8);
        chk("left_release", key_state, 8'h00);
        // Glitch of DC-1 cycles is rejected.
        raw[1] = 1'b0;
        tick(3);
        raw = 8'hFF;
        tick(8);
        chk("glitch_keys", key_state, 8'h00);
        // A held, then buttons selected by a write.
        raw[4] = 1'b0;
        tick(8);
        chk("a_keys", key_state, 8'h10);
        wr(8'h10);
        chk("sel_rdata_pre", bus.p1_rdata, 8'hEF);
        tick(1);
        chk("sel_rdata", bus.p1_rdata, 8'hDE);
        chk("sel_irq", {7'd0, bus.irq}, 8'h01);
        // Both groups selected with A and left held.
        raw[1] = 1'b0;
        tick(8);
        wr(8'h00);
        tick(2);
        chk("both_nibble", {4'h0, bus.p1_rdata[3:0]}, 8'h0C);
        raw[4] = 1'b1;
        tick(8);
        chk("both_release", {4'h0, bus.p1_rdata[3:0]}, 8'h0D);
        // Reset mid-debounce discards the partial count.
        raw = 8'hFF;
        tick(8);
        raw[0] = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdata", bus.p1_rdata, 8'hFF);
        chk("mid_rst_irq", {7'd0, bus.irq}, 8'h00);
        chk("mid_rst_keys", key_state, 8'h00);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("post_rst_wait", key_state, 8'h00);
        tick(1);
        chk("post_rst_press", key_state, 8'h01);
        // Randomised traffic: key changes of random duration, writes and rare resets.
        for (int n = 0; n < 300; n++) begin
            int hold;
            raw  = raw ^ (8'($urandom) & 8'($urandom));
            hold = $urandom_range(1, 10);
            for (int c = 0; c < hold; c++) begin
                bus.p1_sel   = 1'($urandom_range(0, 1));
                bus.p1_wr    = 1'($urandom_range(0, 1));
                bus.p1_wdata = 8'($urandom);
                rst          = ($urandom_range(0, 199) == 0);
                tick(1);
            end
        end
        rst        = 1'b0;
        bus.p1_sel = 1'b0;
        bus.p1_wr  = 1'b0;
        tick(3);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gb_joypad.md
Name: gb_joypad

Overview:
- Game Boy joypad port (P1, 0xFF00) responder: the CPU-facing end of the button path.
- Takes eight raw board buttons, synchronises and debounces them, and presents them through the P1 select/read matrix.
- Raises the joypad interrupt request on any selected line going high-to-low.
- Sits between board KEY/SW pins and the CPU bus/interrupt controller.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles (5 ms at 50 MHz) required to accept a new button level. Must be ≥2.
- RAW_ACTIVE_LOW, 1: 1 = raw input low means pressed (board KEYs); 0 = high means pressed.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- buttons_raw  in  8  unsynchronised buttons: [0]right [1]left [2]up [3]down [4]A [5]B [6]select [7]start.
- p1_sel  in  1  CPU access targets 0xFF00 this cycle.
- p1_wr  in  1  write strobe, qualified by p1_sel.
- p1_wdata  in  8  write data; only bits 5:4 are used.
- p1_rdata  out  8  registered P1 read value.
- irq  out  1  one-cycle joypad interrupt request pulse.
- key_state  out  8  debounced pressed mask, 1 = pressed, same bit order as buttons_raw.

Behaviour:
- Reset values: p1_rdata=8'hFF, irq=0, key_state=8'h00, select bits=2'b11, all debounce counters=0, previous nibble=4'hF.
- Synchroniser: a 2-flop chain per button, then normalised to pressed=1 according to RAW_ACTIVE_LOW.
- Debounce, per button:
  - When the synced level differs from the stable level, the counter increments.
  - When it equals the stable level, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes key_state.
  - Total press latency = 2 sync cycles + DEBOUNCE_CYCLES cycles.
- Select register:
  - When p1_sel and p1_wr are both high, the select bits take p1_wdata[5:4] at the next edge.
  - All other written bits are ignored.
- Lower nibble (active low):
  - P14 (bit 4) = 0 selects directions: right, left, up, down on bits 0-3.
  - P15 (bit 5) = 0 selects buttons: A, B, select, start on bits 0-3.
  - Both selected: each bit = NOR of the two pressed values.
  - Neither selected: 4'hF.
- p1_rdata = {2'b11, select, nibble}, registered every cycle regardless of p1_sel.
  - A select write becomes visible in p1_rdata 1 cycle after the write edge.
- irq:
  - Asserts for exactly one cycle when any bit of the registered nibble is 1 in the previous cycle and 0 in the current cycle.
  - Multiple simultaneous falls produce a single pulse.
  - A fall caused by a select write (pressed key newly selected) also fires irq.
  - Rising transitions never fire.
- Simultaneous select write and debounced change in the same cycle: both apply, and the nibble and irq are computed from the combined result.
- Reset mid-debounce: all progress is discarded; after release of reset every button starts as released.

Optional Feature:
- JOYPAD_TURBO_EN: when defined, adds input port turbo (1 bit) and parameter TURBO_PERIOD (default 2500000).
  - While turbo=1, the effective pressed values of A and B are ANDed with a free-running square wave of period 2*TURBO_PERIOD cycles, so a held button appears as repeated presses.
  - key_state still shows the unmodified debounced level.
  - Each turbo re-press fires irq when the button is selected.
- Undefined: no turbo port and no counter; A and B pass through unchanged.

Decomposition:
- Package gb_joypad_pkg holds:
  - button index constants (BTN_RIGHT..BTN_START);
  - P1_ADDR = 16'hFF00;
  - bit positions P14_BIT=4, P15_BIT=5;
  - P1_RESET = 8'hFF.
- Sub-module key_debounce: one synchroniser plus debounce counter with parameter DEBOUNCE_CYCLES, instantiated 8 times through generate.

Test Plan (DEBOUNCE_CYCLES=4, RAW_ACTIVE_LOW=1):
- Reset, all keys released, no writes -> p1_rdata=8'hFF, irq=0, key_state=8'h00.
- Write 8'h20 (directions selected); hold buttons_raw[1]=0 (left) -> key_state=8'h02 after 6 cycles; next cycle p1_rdata=8'hED; irq pulses for 1 cycle.
- Left line glitch low for 3 cycles, then high -> key_state stays 8'h00, irq stays 0.
- Write 8'h10 (buttons selected) while A is held -> p1_rdata=8'hDE one cycle after the write edge; irq fires once.
- Write 8'h00 with A and left both held -> nibble=4'hC; releasing A -> nibble=4'hD, no irq.
- Assert reset mid-debounce, at count 2 -> outputs return to reset values immediately; the old partial count is not carried over after release.
